// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller and its mult/div busy timer
package hazard_pkg;
  typedef enum logic [0:0] {MD_IDLE, MD_BUSY} md_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEF_MULT_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 32;
endpackage

// File: rtl/md_busy_timer.sv
// md_busy_timer: mult/div busy FSM, busy for exactly N cycles after the issue cycle
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  md_state_t state;
  logic [CW-1:0] cnt;
  // load on issue from idle, count down while busy; a start while busy is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt <= '0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        state <= MD_BUSY;
        cnt <= div ? DIV_LOAD : MULT_LOAD;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else begin
      state <= MD_IDLE;
    end
  end
  assign busy = (state == MD_BUSY);
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && state == MD_BUSY));
endmodule

// File: rtl/hazard_control.sv
// hazard_control: stall/flush generation for load-use, D-stage branch and mult/div hazards; HAZARD_STATS_EN adds stall/flush counters
module hazard_control
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_addrD,
  input  logic [4:0]  rt_addrD,
  input  logic        branchD,
  input  logic        branch_takenD,
  input  logic        hilo_readD,
  input  logic        md_opD,
  input  logic        reg_writeE,
  input  logic        mem_to_regE,
  input  logic [4:0]  write_reg_addrE,
  input  logic        md_startE,
  input  logic        md_divE,
  input  logic        mem_to_regM,
  input  logic [4:0]  write_reg_addrM,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        md_busy
);
  logic hit_e, hit_m, lw_stall, br_stall, md_stall, stall;
  md_busy_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .start(md_startE),
    .div(md_divE),
    .busy(md_busy)
  );
  assign hit_e = write_reg_addrE != REG_ZERO && (write_reg_addrE == rs_addrD || write_reg_addrE == rt_addrD);
  assign hit_m = write_reg_addrM != REG_ZERO && (write_reg_addrM == rs_addrD || write_reg_addrM == rt_addrD);
  assign lw_stall = mem_to_regE && hit_e;
  assign br_stall = branchD && ((reg_writeE && hit_e) || (mem_to_regM && hit_m));
  assign md_stall = (hilo_readD || md_opD) && (md_busy || md_startE);
  assign stall = lw_stall || br_stall || md_stall;
  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = branch_takenD && !stall;
`ifdef HAZARD_STATS_EN
  // count stalled cycles and IF/ID flushes, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall);
      flush_count <= flush_count + 32'(flushD);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: scoreboard bench for hazard_control; checks stats ports when HAZARD_STATS_EN is defined
module tb_hazard_control;
  logic clk = 1'b0, reset;
  logic [4:0] rs_addrD, rt_addrD, write_reg_addrE, write_reg_addrM;
  logic branchD, branch_takenD, hilo_readD, md_opD, reg_writeE, mem_to_regE;
  logic md_startE, md_divE, mem_to_regM;
  logic stallF, stallD, flushD, flushE, md_busy;
  logic [31:0] stall_cycles, flush_count;
  typedef struct packed {
    logic [4:0]  v;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t sb_val[$];
  string sb_tag[$];
  int checks = 0, failures = 0;
  int rem = 0;
  logic last_s = 1'b0, last_f = 1'b0;
  logic [31:0] exp_sc = '0, exp_fc = '0;

  hazard_control dut (
    .clk(clk), .reset(reset),
    .rs_addrD(rs_addrD), .rt_addrD(rt_addrD),
    .branchD(branchD), .branch_takenD(branch_takenD),
    .hilo_readD(hilo_readD), .md_opD(md_opD),
    .reg_writeE(reg_writeE), .mem_to_regE(mem_to_regE),
    .write_reg_addrE(write_reg_addrE),
    .md_startE(md_startE), .md_divE(md_divE),
    .mem_to_regM(mem_to_regM), .write_reg_addrM(write_reg_addrM),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .md_busy(md_busy)
  );
`ifndef HAZARD_STATS_EN
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one cycle and step the reference model using the inputs held during it
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      rem = 0;
      exp_sc = '0;
      exp_fc = '0;
    end else begin
      exp_sc += 32'(last_s);
      exp_fc += 32'(last_f);
      if (rem > 0) rem--;
      else if (md_startE) rem = md_divE ? 32 : 4;
    end
    #1;
  endtask

  task automatic clear();
    reset = 0; rs_addrD = 0; rt_addrD = 0; write_reg_addrE = 0; write_reg_addrM = 0;
    branchD = 0; branch_takenD = 0; hilo_readD = 0; md_opD = 0; reg_writeE = 0;
    mem_to_regE = 0; md_startE = 0; md_divE = 0; mem_to_regM = 0;
  endtask

  // compute the expected outputs for the inputs just driven and queue them
  task automatic push(input string tag);
    logic he, hm, s, f, b;
    exp_t e;
    b = rem > 0;
    he = write_reg_addrE != 0 && (write_reg_addrE == rs_addrD || write_reg_addrE == rt_addrD);
    hm = write_reg_addrM != 0 && (write_reg_addrM == rs_addrD || write_reg_addrM == rt_addrD);
    s = (mem_to_regE && he) || (branchD && ((reg_writeE && he) || (mem_to_regM && hm)))
        || ((hilo_readD || md_opD) && (b || md_startE));
    f = branch_takenD && !s;
    last_s = s;
    last_f = f;
    e.v = {s, s, f, s, b};
    e.sc = exp_sc;
    e.fc = exp_fc;
    sb_val.push_back(e);
    sb_tag.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (sb_val.size() > 0) begin
      exp_t e;
      string t;
      e = sb_val.pop_front();
      t = sb_tag.pop_front();
      check(t, 64'({stallF, stallD, flushD, flushE, md_busy}), 64'(e.v));
`ifdef HAZARD_STATS_EN
      check({t, "_sc"}, 64'(stall_cycles), 64'(e.sc));
      check({t, "_fc"}, 64'(flush_count), 64'(e.fc));
`endif
    end
  end

  initial begin
    clear();
    reset = 1;
    tick(); push("reset0");
    tick(); push("reset1");
    tick(); clear(); push("idle");
    tick(); clear(); mem_to_regE = 1; write_reg_addrE = 8; rs_addrD = 8; push("lw_rs");
    tick(); clear(); push("lw_release");
    tick(); clear(); mem_to_regE = 1; write_reg_addrE = 0; rs_addrD = 0; push("lw_r0");
    tick(); clear(); mem_to_regE = 1; write_reg_addrE = 7; rt_addrD = 7; push("lw_rt");
    tick(); clear(); reg_writeE = 1; write_reg_addrE = 7; rt_addrD = 7; push("alu_no_stall");
    tick(); clear(); branchD = 1; reg_writeE = 1; write_reg_addrE = 9; rt_addrD = 9; push("br_alu");
    tick(); clear(); branchD = 1; rt_addrD = 9; write_reg_addrM = 9; push("br_fwd_m");
    tick(); clear(); branchD = 1; rs_addrD = 9; mem_to_regM = 1; write_reg_addrM = 9; push("br_load_m");
    tick(); clear(); branchD = 1; mem_to_regM = 1; write_reg_addrM = 0; push("br_load_r0");
    tick(); clear(); branch_takenD = 1; mem_to_regE = 1; write_reg_addrE = 5; rs_addrD = 5; push("taken_stalled");
    tick(); clear(); branch_takenD = 1; rs_addrD = 5; push("taken_flush");
    tick(); clear(); push("after_flush");
    tick(); clear(); branch_takenD = 1; push("taken2");
    tick(); clear(); md_startE = 1; md_divE = 1; hilo_readD = 1; push("div_issue");
    for (int i = 1; i <= 33; i++) begin
      tick(); clear(); hilo_readD = 1; push($sformatf("div_mfhi_%0d", i));
    end
    tick(); clear(); md_startE = 1; md_opD = 1; push("mult_issue");
    for (int i = 1; i <= 5; i++) begin
      tick(); clear(); hilo_readD = 1; push($sformatf("mult_mfhi_%0d", i));
    end
    tick(); clear(); md_startE = 1; md_divE = 1; push("div2_issue");
    for (int i = 1; i <= 9; i++) begin
      tick(); clear(); push($sformatf("div2_busy_%0d", i));
    end
    tick(); clear(); reset = 1; push("reset_mid_busy");
    tick(); clear(); hilo_readD = 1; push("after_abort");
    tick(); clear(); md_opD = 1; push("after_abort2");
    for (int i = 0; i < 300; i++) begin
      tick(); clear();
      rs_addrD = 5'($urandom_range(0, 3)); rt_addrD = 5'($urandom_range(0, 3));
      write_reg_addrE = 5'($urandom_range(0, 3)); write_reg_addrM = 5'($urandom_range(0, 3));
      branchD = 1'($urandom); branch_takenD = 1'($urandom); hilo_readD = ($urandom_range(0, 3) == 0);
      md_opD = ($urandom_range(0, 3) == 0); reg_writeE = 1'($urandom); mem_to_regE = 1'($urandom);
      mem_to_regM = 1'($urandom); md_divE = 1'($urandom);
      md_startE = (rem == 0) && ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      push("rand");
    end
    tick(); clear(); reset = 1; push("final_reset");
    tick(); clear(); push("final_idle");
    tick();
    @(negedge clk);
    #1;
    check("drain", 64'(sb_val.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
